// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: widths, reset PC, NOP encoding and
// instruction field bit positions.
package mips_pkg;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
endpackage

// File: rtl/if_id_slot.sv
// One IF/ID storage entry: valid flag, instruction word and PC+4.
// Payload only updates when a valid entry is written, so a cleared slot keeps its last PC.
module if_id_slot #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_PC4 = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              d_vld,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [DATA_W-1:0] d_pc4,
  output logic              vld,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc4
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= 1'b0;
      instr <= '0;
      pc4   <= RST_PC4;
    end else if (en) begin
      vld <= d_vld;
      if (d_vld) begin
        instr <= d_instr;
        pc4   <= d_pc4;
      end
    end
  end
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush and field decode.
// Define IF_ID_SKID_EN for a main + skid entry with a registered in_ready.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [15:0]       imm_o,
  output logic [5:0]        op_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        shamt_o,
  output logic [5:0]        funct_o
);
  localparam logic [DATA_W-1:0] RST_PC4 = RESET_PC + DATA_W'(4);

  logic              acc, main_en, main_dvld, main_vld;
  logic [DATA_W-1:0] main_di, main_dp, main_instr, main_pc4;

  // Flush beats a simultaneous accept: the offered word is dropped.
  assign acc     = in_valid & in_ready & ~flush;
  // Main entry may change when empty or when its contents leave this cycle.
  assign main_en = flush | ~main_vld | out_ready;

`ifdef IF_ID_SKID_EN
  logic              skid_en, skid_dvld, skid_vld, rdy_q;
  logic [DATA_W-1:0] skid_instr, skid_pc4;

  assign main_dvld = ~flush & (skid_vld | acc);
  assign main_di   = skid_vld ? skid_instr : in_instr;
  assign main_dp   = skid_vld ? skid_pc4   : in_pc4;
  // Skid only fills when main is stalled; any main update empties it.
  assign skid_en   = flush | main_en | acc;
  assign skid_dvld = ~flush & ~main_en & acc;

  if_id_slot #(.DATA_W(DATA_W), .RST_PC4(RST_PC4)) u_skid (
    .clk(clk), .reset(reset), .en(skid_en), .d_vld(skid_dvld),
    .d_instr(in_instr), .d_pc4(in_pc4),
    .vld(skid_vld), .instr(skid_instr), .pc4(skid_pc4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= ~(skid_en ? skid_dvld : skid_vld);
  end
  assign in_ready = rdy_q;
`else
  logic started;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) started <= 1'b0;
    else        started <= 1'b1;
  end

  assign main_dvld = acc;
  assign main_di   = in_instr;
  assign main_dp   = in_pc4;
  assign in_ready  = started & (out_ready | ~main_vld);
`endif

  if_id_slot #(.DATA_W(DATA_W), .RST_PC4(RST_PC4)) u_main (
    .clk(clk), .reset(reset), .en(main_en), .d_vld(main_dvld),
    .d_instr(main_di), .d_pc4(main_dp),
    .vld(main_vld), .instr(main_instr), .pc4(main_pc4)
  );

  assign out_valid = main_vld;
  assign instr_o   = main_vld ? main_instr : DATA_W'(NOP);
  assign pc_o      = main_pc4;

  assign op_o    = instr_o[OP_HI:OP_LO];
  assign rs_o    = instr_o[RS_HI:RS_LO];
  assign rt_o    = instr_o[RT_HI:RT_LO];
  assign rd_o    = instr_o[RD_HI:RD_LO];
  assign shamt_o = instr_o[SH_HI:SH_LO];
  assign funct_o = instr_o[FN_HI:FN_LO];
  assign imm_o   = instr_o[IMM_HI:IMM_LO];
endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed scenarios plus random traffic, with a
// queue scoreboard fed on accepts and drained by an output monitor.
module tb_if_id_reg;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc4, instr_o, pc_o;
  logic [15:0] imm_o;
  logic [5:0]  op_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o;

  int n_chk = 0, n_fail = 0;
  logic [63:0] sb[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr, prev_pc;

  if_id_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instr_o(instr_o),
    .pc_o(pc_o), .imm_o(imm_o), .op_o(op_o), .rs_o(rs_o), .rt_o(rt_o),
    .rd_o(rd_o), .shamt_o(shamt_o), .funct_o(funct_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable from posedge+1 to the next posedge, so values
  // seen at negedge are exactly those the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (!out_valid) chk("nop_idle", instr_o, 32'h0);
      chk("fields", {op_o, rs_o, rt_o, rd_o, shamt_o, funct_o}, instr_o);
      chk("imm", {16'h0, imm_o}, {16'h0, instr_o[15:0]});
      if (prev_hold) begin
        chk("stall_instr", instr_o, prev_instr);
        chk("stall_pc", pc_o, prev_pc);
      end
      prev_hold  = out_valid & ~out_ready & ~flush;
      prev_instr = instr_o;
      prev_pc    = pc_o;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got instr %h, expected no output", instr_o);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("sb_instr", instr_o, e[63:32]);
          chk("sb_pc", pc_o, e[31:0]);
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready && !flush) sb.push_back({in_instr, in_pc4});
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0000_3004);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);

    step(); reset = 1'b1;
    @(negedge clk); chk("rdy_before_edge", {31'b0, in_ready}, 32'h0);
    step();
    @(negedge clk); chk("rdy_after_edge", {31'b0, in_ready}, 32'h1);

    // Basic transfer
    step();
    in_valid = 1'b1; in_instr = 32'h3C01DB86; in_pc4 = 32'h3004; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid", {31'b0, out_valid}, 32'h1);
    chk("basic_imm", {16'h0, imm_o}, 32'h0000DB86);
    chk("basic_op", {26'h0, op_o}, 32'h0F);
    chk("basic_rt", {27'h0, rt_o}, 32'h1);
    chk("basic_pc", pc_o, 32'h3004);
    step();

    // Stall hold
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h3C01DB86; in_pc4 = 32'h3008;
    step();
`ifdef IF_ID_SKID_EN
    in_instr = 32'h34210001; in_pc4 = 32'h300C;
`else
    in_valid = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_instr", instr_o, 32'h3C01DB86);
      chk("hold_pc", pc_o, 32'h3008);
      if (k > 0) chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
      step();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    repeat (3) step();

    // Flush with a held entry and a simultaneous offer
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20010005; in_pc4 = 32'h3010;
    step();
    flush = 1'b1; in_instr = 32'h1000FFFF; in_pc4 = 32'h3014;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_instr", instr_o, 32'h0);
      step();
    end

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc4 = 32'h3020 + 32'(4 * i);
      @(negedge clk);
      chk("stream_in_ready", {31'b0, in_ready}, 32'h1);
      if (i > 0) chk("stream_valid", {31'b0, out_valid}, 32'h1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk); chk("stream_valid", {31'b0, out_valid}, 32'h1);
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(19) == 0);
      in_instr  = $urandom;
      in_pc4    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("drain_valid", {31'b0, out_valid}, 32'h0);
    step();

    // Reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8C220004; in_pc4 = 32'h3040;
    step(); in_valid = 1'b0;
    #2;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_pc", pc_o, 32'h0000_3004);
    chk("mid_rst_instr", instr_o, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
    step(); step();
    reset = 1'b1;
    @(negedge clk); chk("rerst_rdy_before", {31'b0, in_ready}, 32'h0);
    step();
    @(negedge clk);
    chk("rerst_rdy_after", {31'b0, in_ready}, 32'h1);
    chk("rerst_valid", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
